md_sched: RTL
=============

Name: md_sched

Overview:
- Multi-cycle multiply/divide controller for the P7 pipeline, sitting beside the EX stage.
- Accepts mult/multu/div/divu/mthi/mtlo from EX and holds HI/LO.
- Models the fixed multi-cycle latency with a busy counter.
- Generates the front-end stall that freezes the IF/ID register while an instruction flagged as HI/LO-using sits in ID.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  EX-stage instruction is an md op; qualifies op
- op  input  3  1=mult 2=multu 3=div 4=divu 5=mthi 6=mtlo; 0/7 = no-op
- rs  input  32  operand A / mthi-mtlo data
- rt  input  32  operand B
- cancel  input  1  EX instruction is being killed (exception/interrupt); suppresses acceptance this cycle
- id_uses_hilo  input  1  hi_lo flag of the instruction currently in ID
- busy  output  1  operation in flight
- stall  output  1  freeze IF/ID, PC and flush ID/EX (combinational)
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset: state IDLE, counter=0, busy=0, hi=0, lo=0, pending result=0. Reset has priority over every other input. Reset mid-operation aborts it; HI/LO read 0 afterwards.
- Acceptance: accept = start && !cancel && state==IDLE && op in 1..6.
  - start while BUSY is ignored; the stall guarantees it never happens legally.
  - cancel with start means nothing is accepted and nothing changes.
- mthi/mtlo, accepted at edge T: hi (resp. lo) <= rs at that edge. No busy cycle. State stays IDLE.
- mult/multu/div/divu, accepted at edge T:
  - Capture the 64-bit result at that edge into pending {ph, pl}.
  - Load counter with N (MULT_CYCLES or DIV_CYCLES). State -> BUSY, busy=1 from T for N cycles.
  - The counter decrements each edge. At the edge where counter goes 1->0, hi<=ph, lo<=pl, state->IDLE, busy=0.
  - Result is visible exactly N edges after acceptance.
  - HI/LO keep their old values while BUSY.
- Arithmetic:
  - mult: signed 32x32 -> 64, {hi,lo}.
  - multu: unsigned 32x32 -> 64, {hi,lo}.
  - div: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend (rs).
  - divu: unsigned quotient to lo, remainder to hi.
  - Divisor rt==0: the operation still takes DIV_CYCLES busy cycles, but hi/lo are left unchanged at completion.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Stall: stall = id_uses_hilo && (busy || (start && !cancel && op in 1..4)).
  - No stall after the completion edge; an mfhi/mflo then reads the new value.
  - No stall for an mthi/mtlo issue.
- cancel while BUSY does not abort the operation in flight; it completes normally.
- Simultaneous events:
  - Completion edge and a new start: the start was rejected in that cycle because busy was still 1.
  - The next operation is accepted on the following cycle at the earliest.
- State machine: IDLE --accept mul/div--> BUSY; BUSY --counter 1->0--> IDLE; any --reset--> IDLE.

Test Plan:
- Reset, then mult rs=0xFFFFFFFD rt=5 (-3*5) -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1. multu on the same operands -> hi=0x00000004, lo=0xFFFFFFF1.
- div rs=0xFFFFFFF9 (-7) rt=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/2 -> lo=3, hi=1.
- Hold id_uses_hilo=1 during a mult issue -> stall=1 in the issue cycle and all 5 busy cycles, stall=0 on the cycle hi/lo update. With id_uses_hilo=0, stall stays 0 throughout.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 on consecutive cycles -> hi/lo update the following edge each, busy never asserts. div by zero after that -> busy 10 cycles, hi/lo remain 0x12345678/0x9ABCDEF0.
- start=1 op=mult with cancel=1 -> busy stays 0, hi/lo unchanged. A start issued while busy (op=mthi) -> ignored, hi unchanged after completion except for the mult result.
- Reset asserted at busy cycle 3 of a div -> next cycle busy=0, stall=0, hi=lo=0. No late writeback occurs.

Source files
------------

// File: rtl/md_sched_if.sv
// EX-stage <-> multiply/divide controller bundle.
interface md_sched_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        cancel;
    logic        id_uses_hilo;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    // Pipeline side: issues ops, observes HI/LO and the stall.
    modport master (
        output start, op, rs, rt, cancel, id_uses_hilo,
        input  busy, stall, hi, lo
    );

    // Controller side.
    modport slave (
        input  start, op, rs, rt, cancel, id_uses_hilo,
        output busy, stall, hi, lo
    );
endinterface

// File: rtl/md_sched.sv
// Multi-cycle mult/div controller: owns HI/LO, models fixed latency with a
// down-counter, and raises the front-end stall while an HI/LO user waits in ID.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_sched_if.slave  bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic [31:0]        ph_q, ph_d, pl_q, pl_d;
    logic               pwe_q, pwe_d;   // pending result gets written (not div-by-zero)

    logic               is_md, is_mt, accept;
    logic [63:0]        mul_s, mul_u;
    logic               sdiv, q_neg, r_neg;
    logic [31:0]        dvd_mag, dvs_mag, dvs_safe, q_mag, r_mag, quot, rem;

    // Decode and acceptance for the instruction currently in EX.
    always_comb begin
        is_md  = (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);
        is_mt  = (bus.op == OP_MTHI) || (bus.op == OP_MTLO);
        accept = bus.start && !bus.cancel && (state_q == IDLE) && (is_md || is_mt);
    end

    // Arithmetic datapath; division works on magnitudes so the
    // 0x80000000 / -1 corner falls out naturally (quotient wraps to 0x80000000).
    always_comb begin
        mul_s    = {{32{bus.rs[31]}}, bus.rs} * {{32{bus.rt[31]}}, bus.rt};
        mul_u    = {32'b0, bus.rs} * {32'b0, bus.rt};
        sdiv     = (bus.op == OP_DIV);
        dvd_mag  = (sdiv && bus.rs[31]) ? -bus.rs : bus.rs;
        dvs_mag  = (sdiv && bus.rt[31]) ? -bus.rt : bus.rt;
        // Keep the divider X-free on a zero divisor; its result is discarded then.
        dvs_safe = (dvs_mag == 32'd0) ? 32'd1 : dvs_mag;
        q_mag    = dvd_mag / dvs_safe;
        r_mag    = dvd_mag % dvs_safe;
        q_neg    = sdiv && (bus.rs[31] ^ bus.rt[31]);
        r_neg    = sdiv && bus.rs[31];
        quot     = q_neg ? -q_mag : q_mag;
        rem      = r_neg ? -r_mag : r_mag;
    end

    // Next-state: accept in IDLE, count down in BUSY, write back on 1->0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        ph_d    = ph_q;
        pl_d    = pl_q;
        pwe_d   = pwe_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (bus.op)
                        OP_MTHI: hi_d = bus.rs;
                        OP_MTLO: lo_d = bus.rs;
                        OP_MULT: begin
                            {ph_d, pl_d} = mul_s;
                            pwe_d   = 1'b1;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = BUSY;
                        end
                        OP_MULTU: begin
                            {ph_d, pl_d} = mul_u;
                            pwe_d   = 1'b1;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = BUSY;
                        end
                        default: begin  // div / divu
                            ph_d    = rem;
                            pl_d    = quot;
                            pwe_d   = (bus.rt != 32'd0);
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = BUSY;
                        end
                    endcase
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    if (pwe_q) begin
                        hi_d = ph_q;
                        lo_d = pl_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            ph_q    <= '0;
            pl_q    <= '0;
            pwe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ph_q    <= ph_d;
            pl_q    <= pl_d;
            pwe_q   <= pwe_d;
        end
    end

    // Stall covers the issue cycle and every busy cycle, but only for HI/LO users.
    always_comb begin
        bus.busy  = (state_q == BUSY);
        bus.stall = bus.id_uses_hilo && ((state_q == BUSY) || (bus.start && !bus.cancel && is_md));
        bus.hi    = hi_q;
        bus.lo    = lo_q;
    end
endmodule
